// File: rtl/eeprom_log_writer.sv
// Purpose: gathers logged bytes into a one-page buffer and feeds page-write bursts (never crossing a page) to the I2C leader.
// Latency: a burst is requested the cycle after the page fills or a flush is seen; lead_byte is read combinationally.
// Backpressure: in_ready drops from burst request until ACK; lead_start holds until lead_ready. Option macro: EEPROM_WRITE_TIMER_EN.
module eeprom_log_writer #(
    parameter int PAGE_BYTES = 64,
    parameter int RETRY_GAP  = 5000,
    parameter int MAX_RETRY  = 255,
    parameter int TWC_CYCLES = 250000
) (
    input  logic        CLK_50MHz,
    input  logic        RESET_N,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        busy,
    output logic        err,
    output logic        wrapped,
    output logic [14:0] wr_addr,
    output logic        lead_start,
    input  logic        lead_ready,
    output logic [14:0] lead_addr,
    output logic [6:0]  lead_len,
    output logic [7:0]  lead_byte,
    input  logic        lead_byte_rd,
    input  logic        lead_done,
    input  logic        lead_nack
);
    localparam int AW = $clog2(PAGE_BYTES);
    localparam int CW = AW + 1;
    // one timer serves both the retry gap and the write-cycle wait, so size it for the longer
    localparam int TIMER_MAX = (RETRY_GAP > TWC_CYCLES) ? RETRY_GAP : TWC_CYCLES;
    localparam int TW = $clog2(TIMER_MAX + 1);
    localparam logic [CW-1:0] PAGE_CNT  = CW'(PAGE_BYTES);
    localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [TW-1:0] GAP_LAST  = TW'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_RETRY = 3'd3,
        S_ERROR = 3'd4,
        S_TWC   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_buf [PAGE_BYTES];
    logic [14:0]   r_wr_addr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [7:0]    r_retries;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          r_wrapped;

    logic [CW-1:0] w_room;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_fill_done;
    logic          w_flush_hit;
    logic          w_gap_done;
    logic [7:0]    w_retries_inc;
    logic [15:0]   w_addr_sum;

    // room left before the page boundary is 1..PAGE_BYTES, so a burst never wraps inside a page
    assign w_room        = PAGE_CNT - CW'(r_wr_addr[AW-1:0]);
    assign w_accept      = in_valid & w_in_ready;
    assign w_fill_done   = w_accept && ((r_count + CW'(1)) == w_room);
    // a flush on an empty buffer is ignored unless a byte arrives with it
    assign w_flush_hit   = flush && ((r_count != '0) || w_accept);
    assign w_gap_done    = (r_timer == GAP_LAST);
    assign w_retries_inc = r_retries + 8'd1;
    assign w_addr_sum    = {1'b0, r_wr_addr} + 16'(r_count);

`ifdef EEPROM_WRITE_TIMER_EN
    localparam logic [TW-1:0] TWC_LAST = TW'(TWC_CYCLES - 1);
    logic r_flush_pend;
    logic w_twc_done;
    assign w_twc_done = (r_timer == TWC_LAST);

    // remember a flush seen during the write-cycle wait so it fires when the timer expires
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_flush_pend <= 1'b0;
        end else if (r_state != S_TWC) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_hit) begin
            r_flush_pend <= 1'b1;
        end
    end
`endif

    // state register
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_fill_done || w_flush_hit) w_state_nxt = S_START;
            end
            S_START: begin
                if (lead_ready) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (lead_done) begin
                    if (!lead_nack) begin
`ifdef EEPROM_WRITE_TIMER_EN
                        w_state_nxt = S_TWC;
`else
                        w_state_nxt = S_FILL;
`endif
                    end else if (w_retries_inc == RETRY_LIM) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_RETRY;
                    end
                end
            end
            S_RETRY: begin
                if (w_gap_done) w_state_nxt = S_START;
            end
`ifdef EEPROM_WRITE_TIMER_EN
            S_TWC: begin
                if (w_twc_done) begin
                    if (w_fill_done || (r_count == w_room) || r_flush_pend || w_flush_hit)
                        w_state_nxt = S_START;
                    else
                        w_state_nxt = S_FILL;
                end
            end
`endif
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        w_in_ready = 1'b0;
        busy       = 1'b1;
        lead_start = 1'b0;
        case (r_state)
            S_FILL: begin
                busy       = 1'b0;
                w_in_ready = (r_count < w_room);
            end
            S_START: lead_start = 1'b1;
`ifdef EEPROM_WRITE_TIMER_EN
            S_TWC: w_in_ready = (r_count < w_room);
`endif
            default: ;
        endcase
    end

    // address, fill count, read pointer, retry count, wait timer and sticky flags
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_addr <= '0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_retries <= '0;
            r_timer   <= '0;
            r_err     <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_accept) r_count <= r_count + CW'(1);
            if ((r_state == S_RETRY) || (r_state == S_TWC)) r_timer <= r_timer + TW'(1);
            else r_timer <= '0;
            if (r_state == S_START) r_rd_ptr <= '0;
            if (r_state == S_SEND) begin
                // pointer parks on the last byte; surplus read pulses are harmless
                if (lead_byte_rd && (({1'b0, r_rd_ptr} + CW'(1)) < r_count))
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                if (lead_done) begin
                    if (!lead_nack) begin
                        r_wr_addr <= w_addr_sum[14:0];
                        r_count   <= '0;
                        r_retries <= '0;
                        if (w_addr_sum[15]) r_wrapped <= 1'b1;
                    end else begin
                        r_retries <= w_retries_inc;
                    end
                end
            end
            if (w_state_nxt == S_ERROR) r_err <= 1'b1;
        end
    end

    // page buffer: written only while accepting bytes, never reset
    always_ff @(posedge CLK_50MHz) begin
        if (w_accept) r_buf[r_count[AW-1:0]] <= in_data;
    end

    assign in_ready  = w_in_ready;
    assign err       = r_err;
    assign wrapped   = r_wrapped;
    assign wr_addr   = r_wr_addr;
    assign lead_addr = r_wr_addr;
    assign lead_len  = 7'(r_count);
    assign lead_byte = r_buf[r_rd_ptr];

endmodule

// File: tb/tb_eeprom_log_writer.sv
// Bench for eeprom_log_writer: directed and random page traffic against a queue-based page model.
// Latency: n/a.
// Backpressure: bench plays both the byte source and the I2C leader.
module tb_eeprom_log_writer;
    localparam int PB  = 64;
    localparam int GAP = 20;
    localparam int MR  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        lead_ready = 1'b0;
    logic        lead_byte_rd = 1'b0;
    logic        lead_done = 1'b0;
    logic        lead_nack = 1'b0;
    logic        in_ready, busy, err, wrapped, lead_start;
    logic [14:0] wr_addr, lead_addr;
    logic [6:0]  lead_len;
    logic [7:0]  lead_byte;

    int n_checks = 0;
    int n_err = 0;
    int last_wait = 0;

    // reference model: next address, open page contents, phase flags
    int         m_addr;
    bit         m_wrapped, m_err, m_filling;
    int         m_retries;
    logic [7:0] m_page[$];

    eeprom_log_writer #(
        .PAGE_BYTES(PB), .RETRY_GAP(GAP), .MAX_RETRY(MR), .TWC_CYCLES(40)
    ) dut (
        .CLK_50MHz(clk), .RESET_N(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .busy(busy), .err(err), .wrapped(wrapped), .wr_addr(wr_addr),
        .lead_start(lead_start), .lead_ready(lead_ready), .lead_addr(lead_addr),
        .lead_len(lead_len), .lead_byte(lead_byte), .lead_byte_rd(lead_byte_rd),
        .lead_done(lead_done), .lead_nack(lead_nack)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int room();
        return PB - (m_addr % PB);
    endfunction

    task automatic model_reset();
        m_addr = 0; m_wrapped = 0; m_err = 0; m_filling = 1; m_retries = 0;
        m_page.delete();
    endtask

    // called just after a rising edge; reset lands mid-cycle
    task automatic do_reset();
        #2 rst_n = 1'b0;
        in_valid = 0; flush = 0; lead_ready = 0; lead_byte_rd = 0; lead_done = 0; lead_nack = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wrapped", 32'(wrapped), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_lead_start", 32'(lead_start), 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // one source cycle: check readiness, offer a byte and/or flush, update the model
    task automatic drive(input bit v, input logic [7:0] b, input bit fl);
        bit exp_rdy;
        exp_rdy = m_filling && (m_page.size() < room());
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(!m_filling));
        in_valid = v; in_data = b; flush = fl;
        tick();
        in_valid = 0; flush = 0;
        if (v && exp_rdy) m_page.push_back(b);
        if (m_filling && ((m_page.size() == room()) || (fl && (m_page.size() > 0)))) m_filling = 0;
    endtask

    task automatic fill_random();
        int c = 0;
        while (m_filling && c < 1000) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 24) == 0);
            c++;
        end
    endtask

    // play the leader for one burst attempt
    task automatic serve(input bit nack, input bit rd);
        int w;
        int len;
        w = 0;
        while (lead_start !== 1'b1 && w < 4000) begin
            tick();
            w++;
        end
        last_wait = w;
        chk("lead_start_seen", 32'(lead_start), 1);
        if (lead_start !== 1'b1) return;
        len = m_page.size();
        chk("lead_addr", 32'(lead_addr), m_addr);
        chk("lead_len", 32'(lead_len), len);
        repeat ($urandom_range(0, 2)) tick();
        chk("lead_start_held", 32'(lead_start), 1);
        lead_ready = 1; tick(); lead_ready = 0;
        chk("lead_start_drop", 32'(lead_start), 0);
        if (rd) begin
            for (int i = 0; i < len; i++) begin
                chk("lead_byte", 32'(lead_byte), 32'(m_page[i]));
                lead_byte_rd = 1; tick(); lead_byte_rd = 0;
                if ($urandom_range(0, 1) == 1) tick();
            end
            chk("rd_saturate", 32'(lead_byte), 32'(m_page[len-1]));
        end
        lead_done = 1; lead_nack = nack; tick(); lead_done = 0; lead_nack = 0;
        if (!nack) begin
            m_addr += len;
            if (m_addr >= 32768) begin
                m_addr -= 32768;
                m_wrapped = 1;
            end
            m_page.delete();
            m_retries = 0;
            m_filling = 1;
        end else begin
            m_retries++;
            if (m_retries == MR) m_err = 1;
        end
        chk("wr_addr", 32'(wr_addr), m_addr);
        chk("err", 32'(err), 32'(m_err));
        chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    endtask

    initial begin
        int r;
        int w;
        int nn;
        model_reset();
        do_reset();

        // full page of 0x00..0x3F from reset
        for (int i = 0; i < 64; i++) drive(1, 8'(i), 0);
        chk("t1_ready_full", 32'(in_ready), 0);
        serve(0, 1);
        chk("t1_addr", 32'(wr_addr), 32'h40);

        // lead_done outside SEND must not move the address
        drive(1, 8'hA5, 0);
        drive(1, 8'h5A, 0);
        lead_done = 1; lead_nack = 1;
        drive(0, 8'h00, 0);
        lead_done = 0; lead_nack = 0;
        chk("stray_done_addr", 32'(wr_addr), m_addr);
        chk("stray_done_err", 32'(err), 32'(m_err));
        drive(0, 8'h00, 1);
        serve(0, 1);

        // partial page by flush, then the remainder of the page
        do_reset();
        drive(0, 8'h00, 1);
        for (int i = 0; i < 10; i++) drive(1, 8'($urandom), 0);
        drive(0, 8'h00, 1);
        serve(0, 1);
        for (int i = 0; i < 54; i++) drive(1, 8'($urandom), 0);
        chk("t2_ready_after_54", 32'(in_ready), 0);
        serve(0, 1);
        chk("t2_addr", 32'(wr_addr), 32'h40);

        // three NACKs then ACK; retries spaced by the gap
        for (int i = 0; i < 64; i++) drive(1, 8'($urandom), 0);
        serve(1, 1);
        serve(1, 1);
        chk("retry_gap1", 32'(last_wait >= GAP), 1);
        serve(1, 1);
        chk("retry_gap2", 32'(last_wait >= GAP), 1);
        serve(0, 1);
        chk("retry_gap3", 32'(last_wait >= GAP), 1);

        // random traffic with occasional NACKs
        repeat (30) begin
            fill_random();
            nn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            repeat (nn) serve(1, 1);
            serve(0, 1);
        end

        // run the address up to the last page, then wrap
        for (int k = 0; k < 600 && m_addr != 32'h7FC0; k++) begin
            r = room();
            for (int j = 0; j < r; j++) drive(1, 8'($urandom), 0);
            serve(0, 0);
        end
        chk("pre_wrap_addr", 32'(wr_addr), 32'h7FC0);
        chk("pre_wrap_flag", 32'(wrapped), 0);
        for (int j = 0; j < 64; j++) drive(1, 8'($urandom), 0);
        serve(0, 1);
        chk("wrap_addr", 32'(wr_addr), 0);
        chk("wrap_flag", 32'(wrapped), 1);

        // reset in the middle of a burst
        for (int j = 0; j < 64; j++) drive(1, 8'($urandom), 0);
        w = 0;
        while (lead_start !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("mid_start", 32'(lead_start), 1);
        lead_ready = 1; tick(); lead_ready = 0;
        lead_byte_rd = 1; tick(); lead_byte_rd = 0;
        chk("mid_busy", 32'(busy), 1);
        do_reset();
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_addr", 32'(wr_addr), 0);
        for (int j = 0; j < 5; j++) drive(1, 8'($urandom), 0);
        drive(0, 8'h00, 1);
        serve(0, 1);

        // retry exhaustion
        r = room();
        for (int j = 0; j < r; j++) drive(1, 8'($urandom), 0);
        repeat (MR) serve(1, 1);
        chk("err_set", 32'(err), 1);
        for (int j = 0; j < 50; j++) begin
            chk("err_no_start", 32'(lead_start), 0);
            drive(1, 8'($urandom), 0);
        end
        chk("err_sticky", 32'(err), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
